// File: rtl/clock_divider_multi.sv
// Multi-channel clock divider: each channel makes a registered square wave and a
// one-cycle end-of-period tick from clk50, with run-time divisor, enable, reload and sync.
module clock_divider_multi #(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 500
) (
    input  logic                      clk50,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS*WIDTH-1:0] div_in,
    input  logic [CHANNELS-1:0]       div_load,
    input  logic                      sync,
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       pending
);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [WIDTH-1:0] slice;
        logic [WIDTH-1:0] d_q, d_n;
        logic [WIDTH-1:0] p_q, p_n;
        logic [WIDTH-1:0] cnt_q, cnt_n;
        logic [WIDTH-1:0] high_n;
        logic             run_q, run_n;
        logic             pend_q, pend_n;
        logic             clk_q, clk_n;
        logic             tick_q, tick_n;
        logic             last;

        assign slice = div_in[k*WIDTH +: WIDTH];

        always_comb begin
            d_n    = d_q;
            p_n    = p_q;
            cnt_n  = cnt_q;
            run_n  = run_q;
            pend_n = pend_q;
            clk_n  = 1'b0;
            tick_n = 1'b0;
            high_n = '0;
            // A running channel always holds a nonzero divisor, but guard D-1 anyway.
            last   = (d_q == '0) || (cnt_q == d_q - 1'b1);

            if (!en[k]) begin
                // Stop: a pending reload survives, an idle load applies at once.
                run_n = 1'b0;
                cnt_n = '0;
                if (div_load[k]) d_n = slice;
            end else if (!run_q) begin
                if (div_load[k]) d_n = slice;
                if (d_n != '0) begin
                    run_n = 1'b1;
                    cnt_n = '0;
                end
            end else if (last || sync) begin
                // Period boundary (natural or forced): the newest divisor takes effect here.
                cnt_n  = '0;
                pend_n = 1'b0;
                if (div_load[k]) begin
                    d_n = slice;
                end else if (pend_q) begin
                    d_n = p_q;
                end
                if (d_n == '0) run_n = 1'b0;
            end else begin
                cnt_n = cnt_q + 1'b1;
                if (div_load[k]) begin
                    p_n    = slice;
                    pend_n = 1'b1;
                end
            end

            if (run_n) begin
                high_n = d_n - (d_n >> 1);
                clk_n  = (cnt_n < high_n);
                tick_n = (cnt_n == d_n - 1'b1);
            end
        end

        always_ff @(posedge clk50 or negedge rst_n) begin
            if (!rst_n) begin
                d_q    <= WIDTH'(DEFAULT_DIV);
                p_q    <= '0;
                cnt_q  <= '0;
                run_q  <= 1'b0;
                pend_q <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                d_q    <= d_n;
                p_q    <= p_n;
                cnt_q  <= cnt_n;
                run_q  <= run_n;
                pend_q <= pend_n;
                clk_q  <= clk_n;
                tick_q <= tick_n;
            end
        end

        assign clk_out[k] = clk_q;
        assign tick[k]    = tick_q;
        assign pending[k] = pend_q;
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi (2 channels, 16-bit, DEFAULT_DIV=4):
// reset, even/odd divisors, reload, boundary load, sync, stop, zero divisor, async reset.
module tb_clock_divider_multi;

    localparam int CH = 2;
    localparam int W  = 16;

    logic            clk50 = 1'b0;
    logic            rst_n;
    logic [CH-1:0]   en;
    logic [CH*W-1:0] div_in;
    logic [CH-1:0]   div_load;
    logic            sync;
    logic [CH-1:0]   clk_out;
    logic [CH-1:0]   tick;
    logic [CH-1:0]   pending;

    int n_vec = 0;
    int n_err = 0;

    clock_divider_multi #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(4)) dut (
        .clk50   (clk50),
        .rst_n   (rst_n),
        .en      (en),
        .div_in  (div_in),
        .div_load(div_load),
        .sync    (sync),
        .clk_out (clk_out),
        .tick    (tick),
        .pending (pending)
    );

    always #5 clk50 = ~clk50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle away from the edge; load/sync are single-cycle pulses.
    task automatic step();
        @(posedge clk50);
        #1;
        div_load = '0;
        sync     = 1'b0;
    endtask

    // Expected waveform for n edges starting at phase 0; d==0 means channel held at 0.
    task automatic run_check(input int d0, input int d1, input int n);
        int d [CH];
        d[0] = d0;
        d[1] = d1;
        for (int i = 0; i < n; i++) begin
            step();
            for (int k = 0; k < CH; k++) begin
                logic ec, et;
                int   ph;
                ec = 1'b0;
                et = 1'b0;
                if (d[k] != 0) begin
                    ph = i % d[k];
                    ec = (ph < (d[k] - d[k] / 2));
                    et = (ph == d[k] - 1);
                end
                check($sformatf("clk_out[%0d] d=%0d i=%0d", k, d[k], i), 32'(clk_out[k]), 32'(ec));
                check($sformatf("tick[%0d] d=%0d i=%0d", k, d[k], i), 32'(tick[k]), 32'(et));
                check($sformatf("pending[%0d] i=%0d", k, i), 32'(pending[k]), 32'(1'b0));
            end
        end
    endtask

    task automatic load(input logic [CH-1:0] mask, input logic [W-1:0] v0, input logic [W-1:0] v1);
        div_in[0 +: W] = v0;
        div_in[W +: W] = v1;
        div_load       = mask;
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = '0;
        div_in   = '0;
        div_load = '0;
        sync     = 1'b0;
        #12;
        check("reset clk_out", 32'(clk_out), 32'(0));
        check("reset tick", 32'(tick), 32'(0));
        check("reset pending", 32'(pending), 32'(0));
        rst_n = 1'b1;

        // Default divisor 4: 1,1,0,0 for five periods; channel 1 idle.
        en = 2'b01;
        run_check(4, 0, 20);

        // Odd divisor 5 loaded while stopped.
        en = 2'b00;
        step();
        check("stop clk_out", 32'(clk_out), 32'(0));
        check("stop tick", 32'(tick), 32'(0));
        load(2'b01, 16'd5, 16'd0);
        step();
        check("idle load no pending", 32'(pending), 32'(0));
        en = 2'b01;
        run_check(5, 0, 10);

        // Divisor 1: constant high, tick every cycle.
        en = 2'b00;
        step();
        load(2'b01, 16'd1, 16'd0);
        step();
        en = 2'b01;
        run_check(1, 0, 5);

        // Reload 6 while running at D=4; current period finishes first.
        en = 2'b00;
        step();
        load(2'b01, 16'd4, 16'd0);
        step();
        en = 2'b01;
        run_check(4, 0, 1);
        load(2'b01, 16'd6, 16'd0);
        step();
        check("reload pending c1", 32'(pending[0]), 32'(1));
        check("reload clk c1", 32'(clk_out[0]), 32'(1));
        step();
        check("reload pending c2", 32'(pending[0]), 32'(1));
        check("reload clk c2", 32'(clk_out[0]), 32'(0));
        step();
        check("reload pending c3", 32'(pending[0]), 32'(1));
        check("reload tick c3", 32'(tick[0]), 32'(1));
        run_check(6, 0, 12);

        // Load 3 on the wrap edge: applies directly, pending stays low.
        load(2'b01, 16'd3, 16'd0);
        run_check(3, 0, 6);

        // Sync two out-of-phase channels (D=4, D=8).
        en = 2'b00;
        step();
        load(2'b11, 16'd4, 16'd8);
        step();
        en = 2'b10;
        step();
        step();
        step();
        en = 2'b11;
        step();
        step();
        check("out of phase clk_out", 32'(clk_out), 32'(2'b01));
        sync = 1'b1;
        run_check(4, 8, 16);
        run_check(4, 8, 2);

        // Sync forces a pending divisor to apply.
        load(2'b01, 16'd6, 16'd0);
        step();
        check("sync pending set", 32'(pending), 32'(2'b01));
        check("sync pre clk0", 32'(clk_out[0]), 32'(0));
        sync = 1'b1;
        run_check(6, 8, 12);

        // Stop mid-period, then re-enable for a full first period.
        en = 2'b00;
        step();
        check("midstop clk_out", 32'(clk_out), 32'(0));
        check("midstop tick", 32'(tick), 32'(0));
        en = 2'b11;
        run_check(6, 8, 16);

        // Zero divisor never starts.
        en = 2'b00;
        step();
        load(2'b01, 16'd0, 16'd0);
        step();
        en = 2'b01;
        run_check(0, 0, 6);

        // Asynchronous reset mid-period restores DEFAULT_DIV.
        en = 2'b00;
        step();
        load(2'b01, 16'd5, 16'd0);
        step();
        en = 2'b01;
        run_check(5, 0, 3);
        check("pre-reset clk0", 32'(clk_out[0]), 32'(1));
        rst_n = 1'b0;
        #1;
        check("async reset clk_out", 32'(clk_out), 32'(0));
        check("async reset pending", 32'(pending), 32'(0));
        #3;
        rst_n = 1'b1;
        run_check(4, 0, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
